// File: rtl/mb_pkg.sv
// Shared types and defaults for the metaball frame writer.
// Holds the sequencer state enum, field format and default frame geometry.
package mb_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } mb_state_t;

    localparam int MB_FRAC   = 15;
    localparam int MB_ADDR_W = 16;
    localparam int MB_X_W    = 10;
    localparam int MB_Y_W    = 9;
    localparam int MB_WIDTH  = 180;
    localparam int MB_HEIGHT = 90;

    localparam logic [7:0] MB_FG_INDEX = 8'd12;
    localparam logic [7:0] MB_BG_INDEX = 8'd0;

endpackage

// File: rtl/mb_frame_writer_if.sv
// Field-unit, VRAM-write and frame-control signals of the frame writer.
// slave: the frame writer itself; master: the surrounding system.
interface mb_frame_writer_if;
    import mb_pkg::*;

    logic                        i_swap;
    logic                        i_field_valid;
    logic signed [31:0]          i_field;
    logic [MB_X_W-1:0]           o_x;
    logic [MB_Y_W-1:0]           o_y;
    logic                        o_field_req;
    logic                        o_wr_en_a;
    logic                        o_wr_en_b;
    logic [MB_ADDR_W-1:0]        o_wr_addr;
    logic [7:0]                  o_wr_data;
    logic                        o_front_is_a;
    logic                        o_frame_done;
    logic                        o_drop;

    modport slave (
        input  i_swap, i_field_valid, i_field,
        output o_x, o_y, o_field_req, o_wr_en_a, o_wr_en_b, o_wr_addr,
               o_wr_data, o_front_is_a, o_frame_done, o_drop
    );

    modport master (
        output i_swap, i_field_valid, i_field,
        input  o_x, o_y, o_field_req, o_wr_en_a, o_wr_en_b, o_wr_addr,
               o_wr_data, o_front_is_a, o_frame_done, o_drop
    );

endinterface

// File: rtl/mb_pixel_walker.sv
// Raster x/y/address counters; a step at the last pixel wraps everything to 0.
// The linear address is counted alongside x so no multiplier is needed.
module mb_pixel_walker
    import mb_pkg::*;
#(
    parameter int WIDTH  = MB_WIDTH,
    parameter int HEIGHT = MB_HEIGHT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 step,
    output logic [MB_X_W-1:0]    x,
    output logic [MB_Y_W-1:0]    y,
    output logic [MB_ADDR_W-1:0] addr,
    output logic                 last
);

    localparam logic [MB_X_W-1:0] X_LAST = MB_X_W'(WIDTH - 1);
    localparam logic [MB_Y_W-1:0] Y_LAST = MB_Y_W'(HEIGHT - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (step) begin
            if (last) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else if (x == X_LAST) begin
                x    <= '0;
                y    <= y + 1'b1;
                addr <= addr + 1'b1;
            end else begin
                x    <= x + 1'b1;
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mb_frame_writer.sv
// Render sequencer: clears the back buffer, walks every pixel through the field units,
// writes thresholded palette indices and swaps buffers on frame end. Optional macro: MB_SHADE_EN.
module mb_frame_writer
    import mb_pkg::*;
#(
    parameter int         WIDTH    = MB_WIDTH,
    parameter int         HEIGHT   = MB_HEIGHT,
    parameter int         FRAC     = MB_FRAC,
    parameter logic [7:0] FG_INDEX = MB_FG_INDEX,
    parameter logic [7:0] BG_INDEX = MB_BG_INDEX
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mb_frame_writer_if.slave bus
);

    if (WIDTH * HEIGHT > 2 ** MB_ADDR_W) begin : g_size_check
        $error("mb_frame_writer: WIDTH*HEIGHT exceeds the write address range");
    end

    mb_state_t            state;
    logic                 front_is_a;
    logic                 field_req;
    logic                 frame_done;
    logic                 drop;
    logic [MB_X_W-1:0]    x;
    logic [MB_Y_W-1:0]    y;
    logic [MB_ADDR_W-1:0] addr;
    logic                 last;
    logic                 pixel_wr;
    logic                 wr_any;
    logic                 walk_clr;
    logic signed [31:0]   level;
    logic [7:0]           pixel;

    // Strobe is gated by reset so an aborted frame never writes in the reset cycle.
    assign pixel_wr = (state == WAIT) && bus.i_field_valid;
    assign wr_any   = i_rst && ((state == CLEAR) || pixel_wr);
    assign walk_clr = (state == DONE) && bus.i_swap;

    mb_pixel_walker #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_walker (
        .clk (i_clk),
        .rst (i_rst),
        .clr (walk_clr),
        .step(wr_any),
        .x   (x),
        .y   (y),
        .addr(addr),
        .last(last)
    );

    assign level = bus.i_field >>> FRAC;

`ifdef MB_SHADE_EN
    logic [2:0] shade;

    always_comb begin
        shade = 3'd0;
        if (level >= 32'sd7) begin
            shade = 3'd7;
        end else if (level > 32'sd0) begin
            shade = level[2:0];
        end
    end

    assign pixel = (shade == 3'd0) ? BG_INDEX : FG_INDEX + {5'd0, shade} - 8'd1;
`else
    assign pixel = (level > 32'sd0) ? FG_INDEX : BG_INDEX;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= CLEAR;
            front_is_a <= 1'b1;
            field_req  <= 1'b0;
            frame_done <= 1'b0;
            drop       <= 1'b0;
        end else begin
            field_req <= 1'b0;
            drop      <= bus.i_swap && (state != DONE);
            unique case (state)
                CLEAR: begin
                    if (last) begin
                        state     <= REQ;
                        field_req <= 1'b1;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.i_field_valid) begin
                        if (last) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state     <= REQ;
                            field_req <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.i_swap) begin
                        state      <= CLEAR;
                        front_is_a <= ~front_is_a;
                        frame_done <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.o_x          = x;
    assign bus.o_y          = y;
    assign bus.o_field_req  = field_req;
    assign bus.o_wr_en_a    = wr_any && !front_is_a;
    assign bus.o_wr_en_b    = wr_any && front_is_a;
    assign bus.o_wr_addr    = addr;
    assign bus.o_wr_data    = (state == WAIT) ? pixel : BG_INDEX;
    assign bus.o_front_is_a = front_is_a;
    assign bus.o_frame_done = frame_done;
    assign bus.o_drop       = drop;

endmodule

// File: tb/tb_mb_frame_writer.sv
// Directed bench for mb_frame_writer on a 4x3 frame with field units answering 3 cycles after req.
// Expected palette data follows MB_SHADE_EN when the bench is built with it.
module tb_mb_frame_writer;
    import mb_pkg::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mb_frame_writer_if bus ();

    mb_frame_writer #(
        .WIDTH (W),
        .HEIGHT(H)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] field_tab [N];
    int          fm_cnt;
    int          fm_idx;

    // Field-unit model: valid (with the table value) in the third cycle after the req cycle.
    initial begin
        bus.i_field_valid = 1'b0;
        bus.i_field       = '0;
        fm_cnt            = 0;
        fm_idx            = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_field_valid = 1'b0;
            if (!rst) begin
                fm_cnt = 0;
            end else begin
                if (fm_cnt > 0) begin
                    fm_cnt--;
                    if (fm_cnt == 0) begin
                        bus.i_field_valid = 1'b1;
                        bus.i_field       = field_tab[fm_idx];
                    end
                end
                if (bus.o_field_req) begin
                    fm_cnt = 3;
                    fm_idx = int'(bus.o_y) * W + int'(bus.o_x);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    logic        la [32];
    logic        lb [32];
    logic [15:0] ad [32];
    logic [7:0]  dt [32];
    logic [9:0]  xl [32];
    logic [8:0]  yl [32];
    int          cl [32];
    bit          inj[32];
    int          drop_cyc[4];
    int          ndrop;
    bit          front_chg;
    int          done_cyc;

    // Runs until o_frame_done, logging writes and drop pulses; injects i_swap on chosen writes.
    task automatic run_frame(input int max_cyc, output int nwr, output bit tmo);
        logic front0;
        nwr       = 0;
        ndrop     = 0;
        front_chg = 1'b0;
        done_cyc  = -1;
        tmo       = 1'b1;
        front0    = bus.o_front_is_a;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            bus.i_swap = 1'b0;
            if (bus.o_drop) begin
                if (ndrop < 4) drop_cyc[ndrop] = c;
                ndrop++;
            end
            if (bus.o_front_is_a !== front0) front_chg = 1'b1;
            if (bus.o_frame_done) begin
                done_cyc = c;
                tmo      = 1'b0;
                break;
            end
            if (bus.o_wr_en_a || bus.o_wr_en_b) begin
                if (nwr < 32) begin
                    la[nwr] = bus.o_wr_en_a;
                    lb[nwr] = bus.o_wr_en_b;
                    ad[nwr] = bus.o_wr_addr;
                    dt[nwr] = bus.o_wr_data;
                    xl[nwr] = bus.o_x;
                    yl[nwr] = bus.o_y;
                    cl[nwr] = c;
                    if (inj[nwr]) bus.i_swap = 1'b1;
                end
                nwr++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.o_front_is_a !== 1'b1) begin miscompares++; $display("FAIL reset_front got=%0b want=1", bus.o_front_is_a); end
        vectors++; if (bus.o_wr_en_a !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en_a got=%0b want=0", bus.o_wr_en_a); end
        vectors++; if (bus.o_wr_en_b !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en_b got=%0b want=0", bus.o_wr_en_b); end
        vectors++; if (bus.o_field_req !== 1'b0) begin miscompares++; $display("FAIL reset_field_req got=%0b want=0", bus.o_field_req); end
        vectors++; if (bus.o_frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got=%0b want=0", bus.o_frame_done); end
        vectors++; if (bus.o_drop !== 1'b0) begin miscompares++; $display("FAIL reset_drop got=%0b want=0", bus.o_drop); end
        vectors++; if (bus.o_wr_addr !== 16'd0) begin miscompares++; $display("FAIL reset_addr got=%0d want=0", bus.o_wr_addr); end
        vectors++; if (bus.o_x !== 10'd0 || bus.o_y !== 9'd0) begin miscompares++; $display("FAIL reset_xy got=%0d,%0d want=0,0", bus.o_x, bus.o_y); end
    endtask

    task automatic test_clear_after_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            vectors++; if (bus.o_wr_en_b !== 1'b1 || bus.o_wr_en_a !== 1'b0) begin miscompares++; $display("FAIL clr_b_en[%0d] got a=%0b b=%0b want a=0 b=1", i, bus.o_wr_en_a, bus.o_wr_en_b); end
            vectors++; if (bus.o_wr_addr !== 16'(i)) begin miscompares++; $display("FAIL clr_b_addr[%0d] got=%0d want=%0d", i, bus.o_wr_addr, i); end
            vectors++; if (bus.o_wr_data !== 8'd0) begin miscompares++; $display("FAIL clr_b_data[%0d] got=%0d want=0", i, bus.o_wr_data); end
        end
        @(negedge clk);
        vectors++; if (bus.o_field_req !== 1'b1) begin miscompares++; $display("FAIL first_req got=%0b want=1", bus.o_field_req); end
        vectors++; if (bus.o_wr_en_a !== 1'b0 || bus.o_wr_en_b !== 1'b0) begin miscompares++; $display("FAIL req_no_write got a=%0b b=%0b want 0 0", bus.o_wr_en_a, bus.o_wr_en_b); end
        vectors++; if (bus.o_x !== 10'd0 || bus.o_y !== 9'd0) begin miscompares++; $display("FAIL first_req_xy got=%0d,%0d want=0,0", bus.o_x, bus.o_y); end
    endtask

    task automatic test_render_fg();
        int nwr;
        bit tmo;
        for (int i = 0; i < N; i++) field_tab[i] = 32'h0000_8000;
        run_frame(400, nwr, tmo);
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL fg_timeout got=%0b want=0", tmo); end
        vectors++; if (nwr != N) begin miscompares++; $display("FAIL fg_count got=%0d want=%0d", nwr, N); end
        for (int i = 0; i < N; i++) begin
            vectors++; if (lb[i] !== 1'b1 || la[i] !== 1'b0) begin miscompares++; $display("FAIL fg_en[%0d] got a=%0b b=%0b want a=0 b=1", i, la[i], lb[i]); end
            vectors++; if (ad[i] !== 16'(i)) begin miscompares++; $display("FAIL fg_addr[%0d] got=%0d want=%0d", i, ad[i], i); end
            vectors++; if (dt[i] !== 8'd12) begin miscompares++; $display("FAIL fg_data[%0d] got=%0d want=12", i, dt[i]); end
            vectors++; if (xl[i] !== 10'(i % W) || yl[i] !== 9'(i / W)) begin miscompares++; $display("FAIL fg_xy[%0d] got=%0d,%0d want=%0d,%0d", i, xl[i], yl[i], i % W, i / W); end
        end
        vectors++; if (cl[1] - cl[0] != 4) begin miscompares++; $display("FAIL fg_pixel_period got=%0d want=4", cl[1] - cl[0]); end
        vectors++; if (done_cyc != cl[N-1] + 1) begin miscompares++; $display("FAIL fg_done_cycle got=%0d want=%0d", done_cyc, cl[N-1] + 1); end
    endtask

    task automatic test_swap();
        bus.i_swap = 1'b1;
        @(posedge clk);
        #1 bus.i_swap = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) begin
                vectors++; if (bus.o_front_is_a !== 1'b0) begin miscompares++; $display("FAIL swap_front got=%0b want=0", bus.o_front_is_a); end
                vectors++; if (bus.o_frame_done !== 1'b0) begin miscompares++; $display("FAIL swap_done_clear got=%0b want=0", bus.o_frame_done); end
                vectors++; if (bus.o_drop !== 1'b0) begin miscompares++; $display("FAIL swap_no_drop got=%0b want=0", bus.o_drop); end
            end
            vectors++; if (bus.o_wr_en_a !== 1'b1 || bus.o_wr_en_b !== 1'b0) begin miscompares++; $display("FAIL clr_a_en[%0d] got a=%0b b=%0b want a=1 b=0", i, bus.o_wr_en_a, bus.o_wr_en_b); end
            vectors++; if (bus.o_wr_addr !== 16'(i) || bus.o_wr_data !== 8'd0) begin miscompares++; $display("FAIL clr_a_wr[%0d] got addr=%0d data=%0d want addr=%0d data=0", i, bus.o_wr_addr, bus.o_wr_data, i); end
        end
    endtask

    task automatic test_threshold();
        int nwr;
        bit tmo;
        logic [7:0] exp_d [N];
        field_tab = '{32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000, 32'h0001_8000,
                      32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_FFFF,
                      32'h0001_0000, 32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000};
`ifdef MB_SHADE_EN
        exp_d = '{8'd0, 8'd0, 8'd12, 8'd14, 8'd18, 8'd0, 8'd0, 8'd12, 8'd13, 8'd0, 8'd0, 8'd12};
`else
        exp_d = '{8'd0, 8'd0, 8'd12, 8'd12, 8'd12, 8'd0, 8'd0, 8'd12, 8'd12, 8'd0, 8'd0, 8'd12};
`endif
        run_frame(400, nwr, tmo);
        vectors++; if (tmo !== 1'b0 || nwr != N) begin miscompares++; $display("FAIL thr_frame got tmo=%0b count=%0d want tmo=0 count=%0d", tmo, nwr, N); end
        for (int i = 0; i < N; i++) begin
            vectors++; if (la[i] !== 1'b1 || lb[i] !== 1'b0) begin miscompares++; $display("FAIL thr_en[%0d] got a=%0b b=%0b want a=1 b=0", i, la[i], lb[i]); end
            vectors++; if (ad[i] !== 16'(i)) begin miscompares++; $display("FAIL thr_addr[%0d] got=%0d want=%0d", i, ad[i], i); end
            vectors++; if (dt[i] !== exp_d[i]) begin miscompares++; $display("FAIL thr_data[%0d] got=%0d want=%0d", i, dt[i], exp_d[i]); end
        end
    endtask

    task automatic test_drop();
        int nwr;
        bit tmo;
        int nb;
        for (int i = 0; i < N; i++) field_tab[i] = 32'h0000_8000;
        bus.i_swap = 1'b1;
        @(posedge clk);
        #1 bus.i_swap = 1'b0;
        vectors++; if (bus.o_front_is_a !== 1'b1) begin miscompares++; $display("FAIL drop_pre_swap_front got=%0b want=1", bus.o_front_is_a); end
        for (int i = 0; i < 32; i++) inj[i] = 1'b0;
        inj[3]  = 1'b1;
        inj[17] = 1'b1;
        inj[23] = 1'b1;
        run_frame(600, nwr, tmo);
        for (int i = 0; i < 32; i++) inj[i] = 1'b0;
        vectors++; if (tmo !== 1'b0) begin miscompares++; $display("FAIL drop_done_reached got tmo=%0b want 0", tmo); end
        vectors++; if (nwr != 2 * N) begin miscompares++; $display("FAIL drop_count got=%0d want=%0d", nwr, 2 * N); end
        nb = 0;
        for (int i = 0; i < 2 * N; i++) if (lb[i] === 1'b1 && la[i] === 1'b0) nb++;
        vectors++; if (nb != 2 * N) begin miscompares++; $display("FAIL drop_b_writes got=%0d want=%0d", nb, 2 * N); end
        vectors++; if (ndrop != 3) begin miscompares++; $display("FAIL drop_pulses got=%0d want=3", ndrop); end
        vectors++; if (drop_cyc[0] != cl[3] + 1) begin miscompares++; $display("FAIL drop_clear_cycle got=%0d want=%0d", drop_cyc[0], cl[3] + 1); end
        vectors++; if (drop_cyc[1] != cl[17] + 1) begin miscompares++; $display("FAIL drop_wait_cycle got=%0d want=%0d", drop_cyc[1], cl[17] + 1); end
        vectors++; if (drop_cyc[2] != cl[23] + 1) begin miscompares++; $display("FAIL drop_last_cycle got=%0d want=%0d", drop_cyc[2], cl[23] + 1); end
        vectors++; if (front_chg !== 1'b0) begin miscompares++; $display("FAIL drop_front_changed got=%0b want=0", front_chg); end
        vectors++; if (ad[23] !== 16'd11 || dt[23] !== 8'd12) begin miscompares++; $display("FAIL drop_last_write got addr=%0d data=%0d want addr=11 data=12", ad[23], dt[23]); end
        @(negedge clk);
        vectors++; if (bus.o_frame_done !== 1'b1 || bus.o_drop !== 1'b0) begin miscompares++; $display("FAIL drop_after got done=%0b drop=%0b want done=1 drop=0", bus.o_frame_done, bus.o_drop); end
    endtask

    task automatic test_reset_mid();
        int  n;
        bit  hit;
        int  nwr;
        bit  tmo;
        logic [7:0] exp_fg;
`ifdef MB_SHADE_EN
        exp_fg = 8'd14;
`else
        exp_fg = 8'd12;
`endif
        for (int i = 0; i < N; i++) field_tab[i] = 32'h0001_8000;
        bus.i_swap = 1'b1;
        @(posedge clk);
        #1 bus.i_swap = 1'b0;
        n   = 0;
        hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (bus.o_wr_en_a || bus.o_wr_en_b) begin
                if (n == N + 5) begin
                    vectors++; if (bus.o_wr_addr !== 16'd5 || bus.o_wr_en_a !== 1'b1) begin miscompares++; $display("FAIL mid_pixel5 got addr=%0d en_a=%0b want addr=5 en_a=1", bus.o_wr_addr, bus.o_wr_en_a); end
                    rst = 1'b0;
                    #1;
                    vectors++; if (bus.o_wr_en_a !== 1'b0 || bus.o_wr_en_b !== 1'b0) begin miscompares++; $display("FAIL mid_no_write got a=%0b b=%0b want 0 0", bus.o_wr_en_a, bus.o_wr_en_b); end
                    hit = 1'b1;
                end
                n++;
            end
        end
        vectors++; if (!hit) begin miscompares++; $display("FAIL mid_pixel5_timeout got writes=%0d want=%0d", n, N + 6); end
        @(posedge clk);
        #1;
        vectors++; if (bus.o_front_is_a !== 1'b1 || bus.o_frame_done !== 1'b0 || bus.o_wr_addr !== 16'd0) begin miscompares++; $display("FAIL mid_reset_state got front=%0b done=%0b addr=%0d want 1 0 0", bus.o_front_is_a, bus.o_frame_done, bus.o_wr_addr); end
        @(posedge clk);
        #1 rst = 1'b1;
        run_frame(400, nwr, tmo);
        vectors++; if (tmo !== 1'b0 || nwr != 2 * N) begin miscompares++; $display("FAIL mid_frame got tmo=%0b count=%0d want tmo=0 count=%0d", tmo, nwr, 2 * N); end
        for (int i = 0; i < N; i++) begin
            vectors++; if (lb[i] !== 1'b1 || la[i] !== 1'b0 || ad[i] !== 16'(i) || dt[i] !== 8'd0) begin miscompares++; $display("FAIL mid_clear[%0d] got a=%0b b=%0b addr=%0d data=%0d want 0 1 %0d 0", i, la[i], lb[i], ad[i], dt[i], i); end
        end
        vectors++; if (lb[N + 5] !== 1'b1 || ad[N + 5] !== 16'd5 || dt[N + 5] !== exp_fg) begin miscompares++; $display("FAIL mid_render5 got b=%0b addr=%0d data=%0d want 1 5 %0d", lb[N + 5], ad[N + 5], dt[N + 5], exp_fg); end
        vectors++; if (dt[2 * N - 1] !== exp_fg || ad[2 * N - 1] !== 16'd11) begin miscompares++; $display("FAIL mid_render11 got addr=%0d data=%0d want 11 %0d", ad[2 * N - 1], dt[2 * N - 1], exp_fg); end
    endtask

    initial begin
        bus.i_swap = 1'b0;
        for (int i = 0; i < 32; i++) inj[i] = 1'b0;
        for (int i = 0; i < N; i++) field_tab[i] = 32'h0000_8000;
        test_reset();
        test_clear_after_reset();
        test_render_fg();
        test_swap();
        test_threshold();
        test_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
